// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encoding, default bus widths and response codes
// used by the APB requester and the APB slaves on the same segment.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 16;
    localparam int APB_DATA_WIDTH = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic APB_RESP_OKAY = 1'b0;
    localparam logic APB_RESP_ERR  = 1'b1;

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB3 requester: valid/ready command in, SETUP/ACCESS on APB, valid/ready response out.
// Optional ACCESS wait timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    logic [1:0] state;

`ifdef APB_MASTER_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        timeout_hit;
    assign timeout_hit = (wait_cnt == 16'(TIMEOUT_CYCLES));
`else
    logic unused_timeout;
    assign unused_timeout = ^16'(TIMEOUT_CYCLES);
`endif

    assign cmd_ready = rst_n && (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= APB_RESP_OKAY;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_wdata;
                        PWRITE  <= cmd_write;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_ACCESS: begin
                    // PSLVERR only matters on the completing cycle
                    if (PREADY) begin
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR ? APB_RESP_ERR : APB_RESP_OKAY;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= ST_RESP;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        rsp_rdata <= '0;
                        rsp_err   <= APB_RESP_ERR;
                        rsp_valid <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-outstanding APB3 requester that converts a valid/ready command stream into APB SETUP/ACCESS transfers.
- Returns each result on a valid/ready response channel.
- Sits between an internal initiator (CPU bridge, DMA, test sequencer) and the APB segment that carries the team's memory-mapped APB slaves.
- Drives exactly one transfer at a time; no address pipelining.

Parameters:
- ADDR_WIDTH, 16, width of PADDR and cmd_addr.
- DATA_WIDTH, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 255, number of ACCESS cycles with PREADY=0 before abort. Used only with the optional feature. Legal range is 1..2^16-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  PSLVERR (or timeout) for this transfer.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err all 0. Any in-flight transfer is dropped; no response is produced for it.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs and rsp_* outputs are registered.
- cmd_ready is combinational: 1 iff state==IDLE (rst_n low forces 0).
- IDLE:
  - On cmd_valid&&cmd_ready at edge E0, latch cmd_addr, cmd_wdata and cmd_write into PADDR, PWDATA and PWRITE.
  - Set PSEL=1, PENABLE=0; go to SETUP.
- SETUP (one cycle): at the next edge set PENABLE=1; go to ACCESS.
- ACCESS:
  - Hold PSEL, PENABLE, PADDR, PWRITE and PWDATA stable.
  - On an edge sampling PREADY=1:
    - rsp_rdata = PWRITE ? 0 : PRDATA.
    - rsp_err = PSLVERR.
    - rsp_valid = 1; PSEL = 0; PENABLE = 0.
    - Go to RESP.
  - PREADY=0 extends ACCESS indefinitely (without the optional feature).
- RESP:
  - Hold rsp_* stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE.
  - rsp_rdata and rsp_err retain their values until the next response.
- Latency with a zero-wait slave: command accepted at E0; PSEL at E0+; PENABLE at E1+; PREADY sampled at E2; rsp_valid at E2+.
  - With rsp_ready tied to 1: cmd_ready=1 again after E3, giving 4 cycles per transfer.
  - Each slave wait state adds one cycle.
- PADDR, PWRITE and PWDATA keep their last values in IDLE and RESP (no toggling when PSEL=0).
- PREADY and PSLVERR are ignored outside ACCESS. PSLVERR is sampled only together with PREADY=1.
- Address is passed through unmodified; no alignment or range check.
- cmd_valid held while not ready: no effect; the command stays pending on the upstream side.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - 16-bit wait counter cleared on entry to ACCESS; increments each ACCESS cycle with PREADY=0.
  - When the counter equals TIMEOUT_CYCLES and PREADY=0, abort: PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata=0; go to RESP.
  - PREADY=1 in the same cycle as the counter match wins as a normal completion.
- Undefined: no counter logic; ACCESS waits indefinitely for PREADY.

Decomposition:
- Package apb_pkg holds:
  - FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3).
  - Default ADDR_WIDTH/DATA_WIDTH constants, shared with the APB slave.
  - APB_RESP_OKAY=1'b0 and APB_RESP_ERR=1'b1.
- Single module; the timeout counter is small enough to stay inline, so no sub-module.

Test Plan:
- Write, zero-wait slave: cmd write addr 0x0010 data 0xDEADBEEF → PSEL 1 cycle before PENABLE; PADDR=0x0010 and PWDATA=0xDEADBEEF stable; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read-back with 1 wait state: read 0x0010, PREADY low 1 ACCESS cycle → ACCESS lasts 2 cycles; rsp_rdata=0xDEADBEEF; rsp_err=0.
- Slave error: read 0x0800, slave returns PREADY=1, PSLVERR=1 → rsp_err=1; next command proceeds normally.
- Backpressure: rsp_ready low 5 cycles → rsp_valid/rsp_rdata held; cmd_ready=0 throughout; PSEL=0 throughout; cmd_ready=1 the cycle after the handshake.
- Reset mid-ACCESS: rst_n low while PENABLE=1 → PSEL, PENABLE and rsp_valid 0 immediately; no response after release; the next command completes normally.
- Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8): PREADY held 0 → abort after 8 wait cycles with rsp_err=1, rsp_rdata=0, PSEL=0. Without the macro the bus stays in ACCESS for 100 cycles.
